// File: rtl/prio_enc_reg_pkg.sv
// Shared types and constants for the registered priority encoder.
// Holds the slot state enum, the code-width helper and the reset values.
package prio_enc_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   function automatic int code_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam state_t RST_STATE = EMPTY;
   localparam int     RST_CODE  = 0;
   localparam int     RST_LAST  = 0;

endpackage

// File: rtl/prio_enc_reg_if.sv
// Request/code handshake bundle between request sources, the encoder and its consumer.
// The master side is the encoder; the slave side drives requests and ready.
interface prio_enc_reg_if
   import prio_enc_pkg::*;
#(
   parameter int N = 4
) ();

   localparam int W = code_width(N);

   logic [N-1:0] req;
   logic [W-1:0] code;
   logic         valid;
   logic         ready;
   logic [N-1:0] pending;

   modport master (
      input  req,
      input  ready,
      output code,
      output valid,
      output pending
   );

   modport slave (
      output req,
      output ready,
      input  code,
      input  valid,
      input  pending
   );

endinterface

// File: rtl/prio_enc_reg_pick.sv
// Combinational pick over the pending vector: searches rotate-1, rotate-2, ... down to rotate
// (modulo N), so rotate=0 degenerates to plain highest-index-wins priority.
module prio_pick
   import prio_enc_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = code_width(N)
) (
   input  logic [N-1:0] pending,
   input  logic [W-1:0] rotate,
   output logic [W-1:0] idx,
   output logic [N-1:0] clear_mask,
   output logic         found
);

   int j;

   // Walk from the farthest candidate to the nearest so the nearest set bit overwrites the others.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int i = N; i >= 1; i--) begin
         j = int'(rotate) - i;
         if (j < 0) begin
            j = j + N;
         end
         if (pending[j]) begin
            idx   = W'(j);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      clear_mask = '0;
      if (found) begin
         clear_mask[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/prio_enc_reg.sv
// Registered priority encoder: accumulates request pulses and drains them one code per handshake.
// Define PRIO_ENC_RR_EN for round-robin arbitration; otherwise fixed priority (highest index wins).
module prio_enc_reg
   import prio_enc_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = code_width(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   prio_enc_reg_if.master bus
);

   state_t       state_q;
   state_t       state_d;
   logic [N-1:0] pending_q;
   logic [W-1:0] code_q;
   logic [W-1:0] pick_idx;
   logic [N-1:0] clear_mask;
   logic         pick_found;
   logic [W-1:0] rotate;
   logic         valid;
   logic         load;

   prio_pick #(.N(N)) u_pick (
      .pending    (pending_q),
      .rotate     (rotate),
      .idx        (pick_idx),
      .clear_mask (clear_mask),
      .found      (pick_found)
   );

`ifdef PRIO_ENC_RR_EN
   logic [W-1:0] last_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q <= W'(RST_LAST);
      end else if (load) begin
         last_q <= pick_idx;
      end
   end

   assign rotate = last_q;
`else
   assign rotate = '0;
`endif

   assign load = pick_found && (!valid || bus.ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // A handshake with more work pending reloads immediately, so the slot only empties when pending is dry.
   always_comb begin
      state_d = state_q;
      if (load) begin
         state_d = FULL;
      end else if (valid && bus.ready) begin
         state_d = EMPTY;
      end
   end

   always_comb begin
      valid = (state_q == FULL);
   end

   // A request landing on the bit being granted survives the clear and is queued again.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q <= '0;
         code_q    <= W'(RST_CODE);
      end else begin
         pending_q <= (pending_q & ~(load ? clear_mask : '0)) | bus.req;
         if (load) begin
            code_q <= pick_idx;
         end
      end
   end

   assign bus.code    = code_q;
   assign bus.valid   = valid;
   assign bus.pending = pending_q;

endmodule

// File: tb/tb_prio_enc_reg.sv
// Self-checking bench for prio_enc_reg: directed scenarios plus randomized traffic against a model.
// Expectations follow PRIO_ENC_RR_EN when it is defined for the build.
module tb_prio_enc_reg;
   import prio_enc_pkg::*;

   localparam int N = 4;
   localparam int W = code_width(N);

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [N-1:0] m_pending;
   logic         m_valid;
   logic [W-1:0] m_code;
   int           m_last;

   prio_enc_reg_if #(.N(N)) bus ();

   prio_enc_reg #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grant order from the rules: fixed priority scans N-1 downward; round-robin starts just below the last grant.
   function automatic int model_pick(input logic [N-1:0] p, input int last);
      int cand;
      for (int i = 1; i <= N; i++) begin
`ifdef PRIO_ENC_RR_EN
         cand = ((last - i) % N + N) % N;
`else
         cand = N - i;
`endif
         if (p[cand]) return cand;
      end
      return -1;
   endfunction

   task automatic step(input logic [N-1:0] r, input logic rd, input logic rn);
      int           pick;
      logic         do_load;
      logic [N-1:0] nxt;
      bus.req   = r;
      bus.ready = rd;
      rst_n     = rn;
      pick      = model_pick(m_pending, m_last);
      do_load   = (pick >= 0) && (!m_valid || rd);
      @(posedge clk);
      if (!rn) begin
         m_pending = '0;
         m_valid   = 1'b0;
         m_code    = '0;
         m_last    = 0;
      end else begin
         nxt = m_pending;
         if (do_load) begin
            nxt[pick] = 1'b0;
            m_code    = W'(pick);
            m_valid   = 1'b1;
            m_last    = pick;
         end else if (m_valid && rd) begin
            m_valid = 1'b0;
         end
         m_pending = nxt | r;
      end
      #1;
   endtask

   task automatic do_reset();
      step('0, 1'b0, 1'b0);
      step('0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      bus.req = 4'b1111;
      do_reset();
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_valid got %0b want 0", bus.valid);
      end
      checks++;
      if (bus.code !== 2'd0) begin
         errors++; $display("[TB] FAIL reset_code got %0d want 0", bus.code);
      end
      checks++;
      if (bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL reset_pending got %b want 0000", bus.pending);
      end
   endtask

   task automatic test_single_pulse();
      do_reset();
      step(4'b0100, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0100) begin
         errors++; $display("[TB] FAIL single_latch got v=%0b p=%b want v=0 p=0100", bus.valid, bus.pending);
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'd2 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL single_grant got v=%0b c=%0d p=%b want v=1 c=2 p=0000", bus.valid, bus.code, bus.pending);
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL single_drain got v=%0b p=%b want v=0 p=0000", bus.valid, bus.pending);
      end
   endtask

   task automatic test_burst();
      int exp_codes [3] = '{3, 1, 0};
      do_reset();
      step(4'b1011, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step('0, 1'b1, 1'b1);
         checks++;
         if (bus.valid !== 1'b1 || bus.code !== W'(exp_codes[k])) begin
            errors++; $display("[TB] FAIL burst_%0d got v=%0b c=%0d want v=1 c=%0d", k, bus.valid, bus.code, exp_codes[k]);
         end
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("[TB] FAIL burst_end got v=%0b want 0", bus.valid);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      step(4'b0011, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step('0, 1'b0, 1'b1);
         checks++;
         if (bus.valid !== 1'b1 || bus.code !== 2'd1 || bus.pending !== 4'b0001) begin
            errors++; $display("[TB] FAIL backpressure_%0d got v=%0b c=%0d p=%b want v=1 c=1 p=0001", k, bus.valid, bus.code, bus.pending);
         end
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'd0 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL backpressure_release got v=%0b c=%0d p=%b want v=1 c=0 p=0000", bus.valid, bus.code, bus.pending);
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("[TB] FAIL backpressure_end got v=%0b want 0", bus.valid);
      end
   endtask

   task automatic test_collision();
      do_reset();
      step(4'b1000, 1'b1, 1'b1);
      step(4'b1000, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'd3 || bus.pending !== 4'b1000) begin
         errors++; $display("[TB] FAIL collision_load got v=%0b c=%0d p=%b want v=1 c=3 p=1000", bus.valid, bus.code, bus.pending);
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'd3 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL collision_regrant got v=%0b c=%0d p=%b want v=1 c=3 p=0000", bus.valid, bus.code, bus.pending);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(4'b0101, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
      checks++;
      if (bus.valid !== 1'b1 || bus.code !== 2'd2 || bus.pending !== 4'b0001) begin
         errors++; $display("[TB] FAIL midreset_setup got v=%0b c=%0d p=%b want v=1 c=2 p=0001", bus.valid, bus.code, bus.pending);
      end
      step(4'b1111, 1'b0, 1'b0);
      checks++;
      if (bus.valid !== 1'b0 || bus.code !== 2'd0 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL midreset_clear got v=%0b c=%0d p=%b want v=0 c=0 p=0000", bus.valid, bus.code, bus.pending);
      end
      step('0, 1'b1, 1'b1);
      checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         errors++; $display("[TB] FAIL midreset_after got v=%0b p=%b want v=0 p=0000", bus.valid, bus.pending);
      end
   endtask

   task automatic test_continuous();
      int exp;
      do_reset();
      step(4'b1111, 1'b1, 1'b1);
      for (int k = 0; k < 8; k++) begin
         step(4'b1111, 1'b1, 1'b1);
`ifdef PRIO_ENC_RR_EN
         exp = 3 - (k % 4);
`else
         exp = 3;
`endif
         checks++;
         if (bus.valid !== 1'b1 || bus.code !== W'(exp)) begin
            errors++; $display("[TB] FAIL continuous_%0d got v=%0b c=%0d want v=1 c=%0d", k, bus.valid, bus.code, exp);
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic         rd;
      logic         rn;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         r  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         rd = ($urandom_range(0, 3) != 0);
         rn = ($urandom_range(0, 59) != 0);
         step(r, rd, rn);
         checks++;
         if (bus.valid !== m_valid || bus.pending !== m_pending || (m_valid && bus.code !== m_code)) begin
            errors++;
            $display("[TB] FAIL random_%0d got v=%0b c=%0d p=%b want v=%0b c=%0d p=%b",
                     k, bus.valid, bus.code, bus.pending, m_valid, m_code, m_pending);
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      m_pending = '0;
      m_valid   = 1'b0;
      m_code    = '0;
      m_last    = 0;
      bus.req   = '0;
      bus.ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      test_reset();
      test_single_pulse();
      test_burst();
      test_backpressure();
      test_collision();
      test_reset_mid();
      test_continuous();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
